div_unit_ctrl: RTL and testbench

//  Execute-stage sequencer directly upstream of divider_top. Accepts one RV64M divide/remainder op
//  (DIV/DIVU/REM/REMU and W forms), resolves divide-by-zero and signed overflow without the

---
 rtl/div_unit_ctrl_pkg.sv | 29 ++
 rtl/div_unit_ctrl_if.sv | 32 +++
 rtl/divider_top.sv | 94 +++++++++
 rtl/div_unit_ctrl.sv | 150 +++++++++++++++
 tb/tb_div_unit_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_unit_ctrl_pkg.sv
// Purpose: shared types and constants for the divide sequencer and its divider.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package div_unit_ctrl_pkg;

    typedef logic [63:0] u64;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_t;

    localparam int DIV_LATENCY_DEFAULT = 66;

    function automatic u64 sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic op_is_signed(input div_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_div(input div_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/div_unit_ctrl_if.sv
// Purpose: request/response handshake bundle between the pipeline and div_unit_ctrl.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready on the request side, resp_valid/resp_ready on the response side.
// Ports: flush, req_{valid,ready,op,word,a,b,tag}, resp_{valid,ready,data,tag}.
interface div_unit_ctrl_if
    import div_unit_ctrl_pkg::*;
#(
    parameter int TAG_W = 5
);
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    div_op_t          req_op;
    logic             req_word;
    u64               req_a;
    u64               req_b;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    u64               resp_data;
    logic [TAG_W-1:0] resp_tag;

    modport master (
        output flush, req_valid, req_op, req_word, req_a, req_b, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag
    );

    modport slave (
        input  flush, req_valid, req_op, req_word, req_a, req_b, req_tag, resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag
    );
endinterface

// File: rtl/divider_top.sv
// Purpose: 64-bit radix-2 restoring divider; restarts whenever valid rises after being low.
// Latency: c holds the final result 66 cycles after valid first goes high, then stays put.
// Backpressure: none; valid must stay high for the whole operation, dropping it aborts.
// Ports: clk, reset (async active-low), valid, b (dividend), a (divisor),
//        is_signed, get_div (1: quotient, 0: remainder), c (result).
module divider_top
    import div_unit_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic valid,
    input  u64   b,
    input  u64   a,
    input  logic is_signed,
    input  logic get_div,
    output u64   c
);
    logic       active_q,  active_d;
    logic [6:0] iter_q,    iter_d;
    u64         rem_q,     rem_d;
    u64         quo_q,     quo_d;
    u64         dvs_q,     dvs_d;
    logic       neg_quo_q, neg_quo_d;
    logic       neg_rem_q, neg_rem_d;
    logic       get_div_q, get_div_d;

    logic [64:0] shifted;
    logic [64:0] diff;

    always_comb begin
        active_d  = active_q;
        iter_d    = iter_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        get_div_d = get_div_q;

        // Partial remainder is always below the divisor, so shifted < 2*divisor and
        // bit 64 of the difference is a clean borrow flag.
        shifted = {rem_q, quo_q[63]};
        diff    = shifted - {1'b0, dvs_q};

        if (!valid) begin
            active_d = 1'b0;
        end else if (!active_q) begin
            // Cycle 0: load magnitudes and remember the result signs.
            active_d  = 1'b1;
            iter_d    = 7'd0;
            rem_d     = '0;
            quo_d     = (is_signed && b[63]) ? -b : b;
            dvs_d     = (is_signed && a[63]) ? -a : a;
            neg_quo_d = is_signed && (a[63] ^ b[63]);
            neg_rem_d = is_signed && b[63];
            get_div_d = get_div;
        end else if (iter_q != 7'd64) begin
            // Cycles 1..64: one quotient bit each; afterwards the registers hold.
            iter_d = iter_q + 7'd1;
            if (!diff[64]) begin
                rem_d = diff[63:0];
                quo_d = {quo_q[62:0], 1'b1};
            end else begin
                rem_d = shifted[63:0];
                quo_d = {quo_q[62:0], 1'b0};
            end
        end

        c = get_div_q ? (neg_quo_q ? -quo_q : quo_q)
                      : (neg_rem_q ? -rem_q : rem_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q  <= 1'b0;
            iter_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            get_div_q <= 1'b0;
        end else begin
            active_q  <= active_d;
            iter_q    <= iter_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            get_div_q <= get_div_d;
        end
    end
endmodule

// File: rtl/div_unit_ctrl.sv
// Purpose: execute-stage sequencer for RV64M DIV/DIVU/REM/REMU(+W); resolves /0 and overflow inline.
// Latency: DIV_LATENCY+1 cycles accept->resp_valid via the divider, 1 cycle for bypassed cases.
// Backpressure: one op at a time; req_ready only in IDLE, response held until resp_ready.
// Ports: clk, reset (async active-low), io (div_unit_ctrl_if.slave: flush, req_*, resp_*).
module div_unit_ctrl
    import div_unit_ctrl_pkg::*;
#(
    parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT,
    parameter int TAG_W       = 5
) (
    input  logic            clk,
    input  logic            reset,
    div_unit_ctrl_if.slave  io
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int              CNT_W    = $clog2(DIV_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LATENCY - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    div_op_t          op_q,    op_d;
    logic             word_q,  word_d;
    u64               a_q,     a_d;
    u64               b_q,     b_d;
    logic [TAG_W-1:0] tag_q,   tag_d;
    u64               data_q,  data_d;
    logic [TAG_W-1:0] rtag_q,  rtag_d;

    logic div_valid;
    u64   div_c;
    logic req_signed, req_div;
    u64   a_ext, b_ext, byp_res;
    logic div0, ovf;

    always_comb begin
        req_signed = op_is_signed(io.req_op);
        req_div    = op_is_div(io.req_op);

        // W forms: widen the low word so the 64-bit datapath yields the 32-bit answer.
        a_ext = io.req_word ? (req_signed ? sext32(io.req_a[31:0]) : {32'b0, io.req_a[31:0]}) : io.req_a;
        b_ext = io.req_word ? (req_signed ? sext32(io.req_b[31:0]) : {32'b0, io.req_b[31:0]}) : io.req_b;

        div0 = (b_ext == '0);
        // Signed W dividend is already sign-extended, so the 32-bit minimum shows up as 0xFFFF_FFFF_8000_0000.
        ovf  = req_signed && (b_ext == '1) &&
               (a_ext == (io.req_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));

        if (div0) byp_res = req_div ? '1 : a_ext;
        else      byp_res = req_div ? a_ext : '0;
        if (io.req_word) byp_res = sext32(byp_res[31:0]);

        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        word_d  = word_q;
        a_d     = a_q;
        b_d     = b_q;
        tag_d   = tag_q;
        data_d  = data_q;
        rtag_d  = rtag_q;

        case (state_q)
            S_IDLE: begin
                if (io.req_valid) begin
                    op_d   = io.req_op;
                    word_d = io.req_word;
                    a_d    = a_ext;
                    b_d    = b_ext;
                    tag_d  = io.req_tag;
                    cnt_d  = '0;
                    if (div0 || ovf) begin
                        data_d  = byp_res;
                        rtag_d  = io.req_tag;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    data_d  = word_q ? sext32(div_c[31:0]) : div_c;
                    rtag_d  = tag_q;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (io.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush beats a same-cycle accept or handshake; the visible response regs keep their value.
        if (io.flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            data_d  = data_q;
            rtag_d  = rtag_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_DIV;
            word_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            data_q  <= '0;
            rtag_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            word_q  <= word_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            rtag_q  <= rtag_d;
        end
    end

    // Dropping valid outside BUSY is what makes the divider restart cleanly after a flush.
    assign div_valid = (state_q == S_BUSY);

    divider_top divider_inst (
        .clk       (clk),
        .reset     (reset),
        .valid     (div_valid),
        .b         (a_q),
        .a         (b_q),
        .is_signed (op_is_signed(op_q)),
        .get_div   (op_is_div(op_q)),
        .c         (div_c)
    );

    assign io.req_ready  = (state_q == S_IDLE);
    assign io.resp_valid = (state_q == S_DONE);
    assign io.resp_data  = data_q;
    assign io.resp_tag   = rtag_q;
endmodule

// File: tb/tb_div_unit_ctrl.sv
// Purpose: self-checking bench for div_unit_ctrl (directed table, corner sequences, random vs model).
// Latency: expects DIV_LATENCY+1 cycles for divider ops, 1 cycle for bypassed ops.
// Backpressure: exercises held resp_ready, flush and mid-operation reset.
module tb_div_unit_ctrl;
    import div_unit_ctrl_pkg::*;

    localparam int LAT   = 66;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    div_unit_ctrl_if #(.TAG_W(TAG_W)) bus();

    div_unit_ctrl #(.DIV_LATENCY(LAT), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]       op;
        bit               word;
        logic [63:0]      a;
        logic [63:0]      b;
        logic [63:0]      exp;
        int               lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Architectural RV64M semantics, written directly from the ISA rules.
    function automatic void ref_model(input logic [1:0] op, input bit word,
                                      input logic [63:0] a, input logic [63:0] b,
                                      output logic [63:0] res, output bit byp);
        bit sgn;
        bit isdiv;
        logic [31:0] a32, b32, r32;
        sgn   = (op == 2'd0) || (op == 2'd2);
        isdiv = (op == 2'd0) || (op == 2'd1);
        a32   = a[31:0];
        b32   = b[31:0];
        r32   = '0;
        res   = '0;
        if (word) begin
            if (b32 == 0) begin
                byp = 1; r32 = isdiv ? 32'hFFFF_FFFF : a32;
            end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                byp = 1; r32 = isdiv ? a32 : 32'h0;
            end else begin
                byp = 0;
                if (sgn) r32 = isdiv ? $signed(a32) / $signed(b32) : $signed(a32) % $signed(b32);
                else     r32 = isdiv ? a32 / b32 : a32 % b32;
            end
            res = {{32{r32[31]}}, r32};
        end else begin
            if (b == 0) begin
                byp = 1; res = isdiv ? 64'hFFFF_FFFF_FFFF_FFFF : a;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                byp = 1; res = isdiv ? a : 64'h0;
            end else begin
                byp = 0;
                if (sgn) res = isdiv ? $signed(a) / $signed(b) : $signed(a) % $signed(b);
                else     res = isdiv ? a / b : a % b;
            end
        end
    endfunction

    task automatic send(input logic [1:0] op, input bit word, input logic [63:0] a,
                        input logic [63:0] b, input logic [TAG_W-1:0] tag);
        @(negedge clk);
        check("req_ready before accept", {63'b0, bus.req_ready}, 64'd1);
        bus.req_op    = div_op_t'(op);
        bus.req_word  = word;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat, output bit saw_dv);
        lat = 0;
        saw_dv = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (dut.div_valid) saw_dv = 1;
            if (bus.resp_valid) break;
        end
        check("resp_valid within budget", {63'b0, bus.resp_valid}, 64'd1);
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input bit word,
                          input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] tag,
                          input logic [63:0] exp, input int exp_lat, input int hold);
        int lat;
        bit saw;
        send(op, word, a, b, tag);
        wait_resp(lat, saw);
        check({name, " data"}, bus.resp_data, exp);
        check({name, " tag"}, 64'(bus.resp_tag), 64'(tag));
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " divider used"}, {63'b0, saw}, {63'b0, (exp_lat != 1)});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, " hold valid"}, {63'b0, bus.resp_valid}, 64'd1);
            check({name, " hold data"}, bus.resp_data, exp);
            check({name, " hold tag"}, 64'(bus.resp_tag), 64'(tag));
            check({name, " hold req_ready"}, {63'b0, bus.req_ready}, 64'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        @(negedge clk);
        check({name, " idle after handshake"}, {62'b0, bus.req_ready, bus.resp_valid}, 64'b10);
    endtask

    function automatic logic [63:0] pick_operand();
        logic [63:0] v;
        case ($urandom_range(0, 6))
            0: v = 64'h0;
            1: v = 64'hFFFF_FFFF_FFFF_FFFF;
            2: v = 64'h8000_0000_0000_0000;
            3: v = {$urandom, 32'h8000_0000};
            4: v = 64'($urandom_range(0, 20));
            5: v = -64'($urandom_range(1, 20));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp;
        bit byp;
        int lat;
        bit saw;

        vecs[0] = '{2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, LAT + 1};
        vecs[1] = '{2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LAT + 1};
        vecs[2] = '{2'd1, 1'b0, 64'h10, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[3] = '{2'd3, 1'b0, 64'h10, 64'd0, 64'h10, 1};
        vecs[4] = '{2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
        vecs[5] = '{2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1};
        vecs[6] = '{2'd0, 1'b1, 64'h1_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
        vecs[7] = '{2'd1, 1'b1, 64'hFFFF_FFFF, 64'd2, 64'h7FFF_FFFF, LAT + 1};

        reset          = 1'b0;
        bus.flush      = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = OP_DIV;
        bus.req_word   = 1'b0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b0;

        #23;
        check("reset req_ready", {63'b0, bus.req_ready}, 64'd1);
        check("reset resp_valid", {63'b0, bus.resp_valid}, 64'd0);
        check("reset resp_data", bus.resp_data, 64'd0);
        check("reset resp_tag", 64'(bus.resp_tag), 64'd0);
        check("reset divider valid", {63'b0, dut.div_valid}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b,
                   TAG_W'(i + 1), vecs[i].exp, vecs[i].lat, 0);

        // Response held for 5 cycles under backpressure.
        run_op("backpressure", 2'd0, 1'b0, 64'd1000, 64'd7, 5'd21, 64'd142, LAT + 1, 5);

        // Flush at BUSY counter 10, then a fresh op must complete with its own tag.
        send(2'd0, 1'b0, 64'd1000, 64'd3, 5'd7);
        repeat (11) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check("flush busy resp_valid", {63'b0, bus.resp_valid}, 64'd0);
        check("flush busy req_ready", {63'b0, bus.req_ready}, 64'd1);
        check("flush busy divider valid", {63'b0, dut.div_valid}, 64'd0);
        run_op("after flush", 2'd1, 1'b0, 64'd100, 64'd7, 5'd9, 64'd14, LAT + 1, 0);

        // Flush beats a simultaneous accept.
        @(negedge clk);
        bus.req_op = OP_DIV; bus.req_word = 1'b0; bus.req_a = 64'd1; bus.req_b = 64'd0;
        bus.req_tag = 5'd3; bus.req_valid = 1'b1; bus.flush = 1'b1;
        @(posedge clk);
        #1 begin bus.req_valid = 1'b0; bus.flush = 1'b0; end
        @(negedge clk);
        check("flush vs accept resp_valid", {63'b0, bus.resp_valid}, 64'd0);
        check("flush vs accept req_ready", {63'b0, bus.req_ready}, 64'd1);
        check("flush vs accept resp_tag", 64'(bus.resp_tag), 64'd9);

        // Flush beats a simultaneous response handshake.
        send(2'd1, 1'b0, 64'd5, 64'd0, 5'd4);
        wait_resp(lat, saw);
        check("flush vs ready data", bus.resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        bus.flush = 1'b1; bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 begin bus.flush = 1'b0; bus.resp_ready = 1'b0; end
        @(negedge clk);
        check("flush vs ready resp_valid", {63'b0, bus.resp_valid}, 64'd0);
        check("flush vs ready req_ready", {63'b0, bus.req_ready}, 64'd1);

        // Asynchronous reset in the middle of BUSY.
        send(2'd0, 1'b0, 64'd50, 64'd5, 5'd11);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("async reset resp_valid", {63'b0, bus.resp_valid}, 64'd0);
        check("async reset resp_data", bus.resp_data, 64'd0);
        check("async reset resp_tag", 64'(bus.resp_tag), 64'd0);
        check("async reset req_ready", {63'b0, bus.req_ready}, 64'd1);
        check("async reset divider valid", {63'b0, dut.div_valid}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op("after reset", 2'd3, 1'b0, 64'd100, 64'd7, 5'd12, 64'd2, LAT + 1, 0);

        // Randomised ops against the reference model.
        for (int i = 0; i < 25; i++) begin
            logic [1:0]       op;
            bit               word;
            logic [63:0]      a, b;
            logic [TAG_W-1:0] tag;
            op   = 2'($urandom_range(0, 3));
            word = 1'($urandom_range(0, 1));
            a    = pick_operand();
            b    = pick_operand();
            tag  = TAG_W'($urandom_range(0, 31));
            ref_model(op, word, a, b, exp, byp);
            run_op($sformatf("rand%0d op%0d w%0d", i, op, word), op, word, a, b, tag,
                   exp, byp ? 1 : LAT + 1, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
